matrix_stream_loader: RTL and testbench
=======================================

Name: matrix_stream_loader

Overview:
- Synthesizable counterpart to the matrix output writer: consumes a row-major stream of 32-bit words over a strobe/acknowledge handshake and fills an N x N operand buffer.
- Serves the stored matrix through a random-access (i, j) read port with the same shape as the multiplier's a_in/a_i/a_j and b_in/b_i/b_j operand interface.
- Two instances (A and B) replace file-backed operand arrays in front of sequential_matrix_multiplier.

Parameters:
- N, 4, matrix dimension (rows = columns), N >= 2
- WIDTH, 32, element width in bits
- TRANSPOSE, 0, 0: stream word k stored at (k/N, k%N); 1: stored at (k%N, k/N)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0)
- start  input  1  level request to begin a load; acted on only in IDLE
- in_data  input  WIDTH  stream word, valid while in_stb=1
- in_stb  input  1  source strobe; source holds in_stb and in_data until it sees in_ack
- in_ack  output  1  one-cycle pulse acknowledging capture of in_data
- rd_i  input  IDX  read row index, IDX = max(1, clog2(N))
- rd_j  input  IDX  read column index
- rd_data  output  WIDTH  combinational element at (rd_i, rd_j)
- count  output  CW  words captured in the current load, CW = clog2(N*N+1)
- busy  output  1  high in LOAD
- loaded  output  1  high in DONE; buffer complete and stable

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ack=0, count=0, busy=0, loaded=0; row/column counters=0. Buffer contents are not reset.
- States: IDLE, LOAD, DONE (2-bit encoding).
- IDLE:
  - start=1 -> LOAD next cycle; counters cleared.
  - in_stb is ignored and never acknowledged.
- LOAD, capture condition in_stb=1 and in_ack=0:
  - Write in_data at the current (r, c), or at (c, r) when TRANSPOSE=1.
  - Register in_ack=1 for exactly one cycle; count+1.
  - c+1; at c=N-1 wrap c to 0 and r+1.
- Back-to-back handshake:
  - in_ack is forced 0 on the cycle after any pulse, so the earliest next capture is 2 cycles after the previous one (maximum rate 1 word per 2 cycles).
  - A source still holding in_stb on the cycle in_ack is high is not captured twice.
  - A source that keeps in_stb high after in_ack with new data is captured again on the following cycle, and that counts as a new word.
- Completion: the capture of word N*N-1 (r=c=N-1) also moves the state to DONE in the same edge. loaded=1 and busy=0 from the next cycle; count=N*N.
- DONE:
  - Hold loaded=1 and count=N*N.
  - in_stb is ignored, with no ack.
  - start=0 -> IDLE with loaded=0. A new load therefore requires start low, then high; a level-held start never reloads.
- Read port:
  - rd_data = buffer[rd_i][rd_j], combinational, zero latency.
  - A write and a read of the same cell in the same cycle return the old value.
  - Index >= N (non-power-of-2 N) returns 0.
  - Reads are legal in any state; contents are defined only after loaded=1.
- start falling during LOAD has no effect; the load runs to completion.
- Reset mid-LOAD: immediate return to IDLE with all outputs 0. Partially written cells keep their values but are considered invalid.
- Width rules: r, c are IDX bits and never exceed N-1. count saturates at N*N by construction.

Decomposition:
- Shared package matrix_pkg:
  - loader state enum (IDLE/LOAD/DONE)
  - idx_width(N) and count_width(N) functions
  - default WIDTH=32 constant
- One sub-module, matrix_buffer:
  - N*N x WIDTH register array
  - single synchronous write port (we, wi, wj, wdata)
  - combinational read mux with out-of-range zero
- matrix_stream_loader holds the FSM, counters and handshake.

Test Plan:
- N=4, TRANSPOSE=0, stream 1..16 with the source dropping in_stb the cycle after in_ack -> 16 in_ack pulses, loaded=1, count=16, rd(2,3)=12, rd(0,0)=1, rd(3,3)=16.
- N=4, TRANSPOSE=1, same stream -> rd(2,3)=15, rd(3,0)=4, rd(1,0)=2.
- Source holds in_stb=1 with the same data for 5 cycles per word -> exactly one capture per word, count increments by 1 per word, final count=16.
- rst driven low asynchronously (mid-cycle) after 7 captures -> same instant: in_ack=0, busy=0, count=0, state IDLE; after release, start=1 plus a 16-word reload -> loaded=1, every cell holds the new values.
- start held high through completion -> stays in DONE with no reload. start=0 for 1 cycle -> loaded=0. start=1 -> busy=1 and a new load with count=0.
- in_stb=1 while in IDLE and while in DONE -> no in_ack, count unchanged, buffer unchanged. N=3 with rd_i=3 -> rd_data=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader: FSM states, width helpers
// and the default element width.
package matrix_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // Index width for an N-entry dimension, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the values 0..N*N inclusive.
  function automatic int count_width(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Strobe/acknowledge word stream: the source drives data and strobe,
// the loader answers with a one-cycle acknowledge.
interface matrix_stream_loader_if
  import matrix_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_stb;
  logic             in_ack;

  modport master (output in_data, output in_stb, input in_ack);
  modport slave  (input in_data, input in_stb, output in_ack);
endinterface

// File: rtl/matrix_buffer.sv
// N x N operand store: one synchronous write port and a combinational
// (i, j) read port that returns zero for out-of-range indices.
module matrix_buffer
  import matrix_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX  = idx_width(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX-1:0]   wi,
  input  logic [IDX-1:0]   wj,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX-1:0]   rd_i,
  input  logic [IDX-1:0]   rd_j,
  output logic [WIDTH-1:0] rd_data
);
  localparam bit POW2 = (N == (1 << IDX));
  localparam logic [IDX:0] N_L = (IDX + 1)'(N);

  logic [WIDTH-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wi][wj] <= wdata;
    end
  end

  // Only non-power-of-two sizes can see an index past the last row/column.
  generate
    if (POW2) begin : g_full_range
      assign rd_data = mem[rd_i][rd_j];
    end else begin : g_clipped
      always_comb begin
        rd_data = '0;
        if (({1'b0, rd_i} < N_L) && ({1'b0, rd_j} < N_L)) begin
          rd_data = mem[rd_i][rd_j];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/matrix_stream_loader.sv
// Fills an N x N operand buffer from a row-major word stream and serves it
// through a random-access (i, j) read port.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int TRANSPOSE = 0,
  localparam int IDX      = idx_width(N),
  localparam int CW       = count_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  matrix_stream_loader_if.slave stream,
  input  logic [IDX-1:0]       rd_i,
  input  logic [IDX-1:0]       rd_j,
  output logic [WIDTH-1:0]     rd_data,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 loaded
);
  localparam logic [IDX-1:0] LAST = IDX'(N - 1);

  loader_state_t  state_reg, state_next;
  logic [IDX-1:0] row_reg, row_next;
  logic [IDX-1:0] col_reg, col_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           ack_reg, ack_next;
  logic           capture;
  logic [IDX-1:0] wi, wj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      count_reg <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      count_reg <= count_next;
      ack_reg   <= ack_next;
    end
  end

  // A pending ack blocks capture, so a held strobe is taken once per pulse.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    count_next = count_reg;
    ack_next   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          row_next   = '0;
          col_next   = '0;
          count_next = '0;
        end
      end
      ST_LOAD: begin
        if (stream.in_stb && !ack_reg) begin
          capture    = 1'b1;
          ack_next   = 1'b1;
          count_next = count_reg + CW'(1);
          if (col_reg == LAST) begin
            col_next = '0;
            if (row_reg == LAST) begin
              row_next   = '0;
              state_next = ST_DONE;
            end else begin
              row_next = row_reg + IDX'(1);
            end
          end else begin
            col_next = col_reg + IDX'(1);
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wi = (TRANSPOSE != 0) ? col_reg : row_reg;
  assign wj = (TRANSPOSE != 0) ? row_reg : col_reg;

  matrix_buffer #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_buffer (
    .clk     (clk),
    .we      (capture),
    .wi      (wi),
    .wj      (wj),
    .wdata   (stream.in_data),
    .rd_i    (rd_i),
    .rd_j    (rd_j),
    .rd_data (rd_data)
  );

  assign stream.in_ack = ack_reg;
  assign count         = count_reg;
  assign busy          = (state_reg == ST_LOAD);
  assign loaded        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench: row-major and transposed N=4 loaders fed from one stream,
// plus an N=3 loader for out-of-range reads.
module tb_matrix_stream_loader;
  import matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start, start3;
  logic [31:0] data, data3;
  logic        stb, stb3;
  logic [1:0]  rd_i, rd_j, rd_i3, rd_j3;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [4:0]  cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        busy_a, busy_b, busy_c;
  logic        loaded_a, loaded_b, loaded_c;

  matrix_stream_loader_if #(.WIDTH(32)) if_a ();
  matrix_stream_loader_if #(.WIDTH(32)) if_b ();
  matrix_stream_loader_if #(.WIDTH(32)) if_c ();

  assign if_a.in_data = data;
  assign if_a.in_stb  = stb;
  assign if_b.in_data = data;
  assign if_b.in_stb  = stb;
  assign if_c.in_data = data3;
  assign if_c.in_stb  = stb3;

  matrix_stream_loader #(.N(4), .WIDTH(32), .TRANSPOSE(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .stream(if_a.slave),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_a),
    .count(cnt_a), .busy(busy_a), .loaded(loaded_a)
  );

  matrix_stream_loader #(.N(4), .WIDTH(32), .TRANSPOSE(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .stream(if_b.slave),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_b),
    .count(cnt_b), .busy(busy_b), .loaded(loaded_b)
  );

  matrix_stream_loader #(.N(3), .WIDTH(32), .TRANSPOSE(0)) u_c (
    .clk(clk), .rst(rst), .start(start3), .stream(if_c.slave),
    .rd_i(rd_i3), .rd_j(rd_j3), .rd_data(rd_c),
    .count(cnt_c), .busy(busy_c), .loaded(loaded_c)
  );

  int checks = 0;
  int errors = 0;
  int acks_a = 0;
  int acks_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the row-major loader's ack, sampling at negedge.
  task automatic wait_ack_a(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (if_a.in_ack === 1'b1) ok = 1'b1;
    end
    check(tag, {31'd0, ok}, 32'd1);
    if (ok) begin
      acks_a++;
      if (if_b.in_ack === 1'b1) acks_b++;
    end
  endtask

  // Present one word; stb stays high through the ack cycle, then drops.
  task automatic send4(input logic [31:0] d, input int gap);
    data = d;
    stb  = 1'b1;
    wait_ack_a("ack_seen");
    tick();
    stb = 1'b0;
    check("ack_one_cycle", {31'd0, if_a.in_ack}, 32'd0);
    repeat (gap) tick();
  endtask

  initial begin
    bit seen;
    int t0, t1;

    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    data = '0; data3 = '0; stb = 1'b0; stb3 = 1'b0;
    rd_i = '0; rd_j = '0; rd_i3 = '0; rd_j3 = '0;
    #1 rst = 1'b0;
    #2;
    $display("step reset: checking outputs under reset");
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_loaded", {31'd0, loaded_a}, 32'd0);
    check("rst_count", {27'd0, cnt_a}, 32'd0);
    check("rst_ack", {31'd0, if_a.in_ack}, 32'd0);
    #9 rst = 1'b1;
    tick();

    $display("step idle_stb: strobe while idle");
    data = 32'd77; stb = 1'b1; seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_a.in_ack !== 1'b0) seen = 1'b1;
    end
    check("idle_no_ack", {31'd0, seen}, 32'd0);
    check("idle_count", {27'd0, cnt_a}, 32'd0);
    check("idle_busy", {31'd0, busy_a}, 32'd0);
    tick();
    stb = 1'b0;

    $display("step load1: stream 1..16, start held high");
    start = 1'b1;
    tick();
    check("load1_busy", {31'd0, busy_a}, 32'd1);
    acks_a = 0; acks_b = 0;
    for (int k = 0; k < 16; k++) send4(32'(k + 1), 0);
    tick();
    check("load1_loaded", {31'd0, loaded_a}, 32'd1);
    check("load1_busy_low", {31'd0, busy_a}, 32'd0);
    check("load1_count", {27'd0, cnt_a}, 32'd16);
    check("load1_acks", 32'(acks_a), 32'd16);
    check("load1_acks_t", 32'(acks_b), 32'd16);
    check("load1_loaded_t", {31'd0, loaded_b}, 32'd1);
    rd_i = 2'd2; rd_j = 2'd3; #1;
    check("rm_rd23", rd_a, 32'd12);
    check("tr_rd23", rd_b, 32'd15);
    rd_i = 2'd0; rd_j = 2'd0; #1;
    check("rm_rd00", rd_a, 32'd1);
    rd_i = 2'd3; rd_j = 2'd3; #1;
    check("rm_rd33", rd_a, 32'd16);
    rd_i = 2'd3; rd_j = 2'd0; #1;
    check("tr_rd30", rd_b, 32'd4);
    rd_i = 2'd1; rd_j = 2'd0; #1;
    check("tr_rd10", rd_b, 32'd2);

    $display("step done_hold: start high, strobe in DONE");
    data = 32'hDEAD; stb = 1'b1; seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (if_a.in_ack !== 1'b0) seen = 1'b1;
    end
    stb = 1'b0;
    tick();
    check("done_no_ack", {31'd0, seen}, 32'd0);
    check("done_loaded", {31'd0, loaded_a}, 32'd1);
    check("done_count", {27'd0, cnt_a}, 32'd16);
    rd_i = 2'd0; rd_j = 2'd0; #1;
    check("done_rd00", rd_a, 32'd1);

    $display("step restart: start low one cycle, then high");
    start = 1'b0;
    tick();
    check("restart_loaded", {31'd0, loaded_a}, 32'd0);
    start = 1'b1;
    tick();
    check("restart_busy", {31'd0, busy_a}, 32'd1);
    check("restart_count", {27'd0, cnt_a}, 32'd0);

    $display("step slow_source: one capture per word");
    for (int k = 0; k < 16; k++) begin
      send4(32'(200 + k), 3);
      check("slow_count", {27'd0, cnt_a}, 32'(k + 1));
    end
    check("slow_loaded", {31'd0, loaded_a}, 32'd1);
    rd_i = 2'd1; rd_j = 2'd2; #1;
    check("slow_rd12", rd_a, 32'd206);

    $display("step b2b: continuous strobe with new data");
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    t0 = 0; t1 = 0;
    data = 32'd300; stb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_ack_a("b2b_ack_seen");
      if (k == 0) t0 = cyc;
      t1 = cyc;
      tick();
      data = 32'(301 + k);
      if (k == 15) stb = 1'b0;
    end
    tick();
    check("b2b_spacing", 32'(t1 - t0), 32'd30);
    check("b2b_count", {27'd0, cnt_a}, 32'd16);
    rd_i = 2'd3; rd_j = 2'd1; #1;
    check("b2b_rd31", rd_a, 32'd313);

    $display("step async_reset: reset after 7 captures");
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) send4(32'(400 + k), 0);
    data = 32'd406; stb = 1'b1;
    wait_ack_a("rst7_ack_seen");
    check("rst7_count", {27'd0, cnt_a}, 32'd7);
    #2 rst = 1'b0;
    #1;
    check("arst_ack", {31'd0, if_a.in_ack}, 32'd0);
    check("arst_busy", {31'd0, busy_a}, 32'd0);
    check("arst_count", {27'd0, cnt_a}, 32'd0);
    check("arst_loaded", {31'd0, loaded_a}, 32'd0);
    stb = 1'b0;
    #3 rst = 1'b1;
    tick();
    check("reload_busy", {31'd0, busy_a}, 32'd1);
    for (int k = 0; k < 16; k++) send4(32'(500 + k), 0);
    tick();
    check("reload_loaded", {31'd0, loaded_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        rd_i = 2'(i); rd_j = 2'(j); #1;
        check("reload_rm_cell", rd_a, 32'(500 + i * 4 + j));
        check("reload_tr_cell", rd_b, 32'(500 + j * 4 + i));
      end
    end
    check("reload_busy_t", {31'd0, busy_b}, 32'd0);
    check("reload_count_t", {27'd0, cnt_b}, 32'd16);

    $display("step n3: 3x3 load and out-of-range reads");
    start3 = 1'b1;
    tick();
    check("n3_busy", {31'd0, busy_c}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      data3 = 32'(k + 1); stb3 = 1'b1; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (if_c.in_ack === 1'b1) seen = 1'b1;
      end
      check("n3_ack_seen", {31'd0, seen}, 32'd1);
      tick();
      stb3 = 1'b0;
    end
    tick();
    check("n3_loaded", {31'd0, loaded_c}, 32'd1);
    check("n3_count", {28'd0, cnt_c}, 32'd9);
    rd_i3 = 2'd2; rd_j3 = 2'd2; #1;
    check("n3_rd22", rd_c, 32'd9);
    rd_i3 = 2'd1; rd_j3 = 2'd0; #1;
    check("n3_rd10", rd_c, 32'd4);
    rd_i3 = 2'd3; rd_j3 = 2'd0; #1;
    check("n3_rd30_zero", rd_c, 32'd0);
    rd_i3 = 2'd0; rd_j3 = 2'd3; #1;
    check("n3_rd03_zero", rd_c, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
